regfile_sb: RTL and testbench

- Parametrised successor to the CPU register file: configurable data width and depth, with x0 optionally hardwired to zero.
- Two write ports:
  - Port A: ALU writeback.
  - Port B: load/memory writeback.
- Per-register scoreboard: busy bits plus a pending-load counter.
- Sits between decode (reads, locks) and the writeback stages. Decode uses the busy flags to stall on load-use hazards.

---
 rtl/cpe_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 75 +++++++
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpe_pkg.sv
// Shared CPU-core definitions: default widths, register index/word types, x0 index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: busy bits, lock acceptance and running busy count.
// Latency: lock_ok and read busy flags are combinational; busy bits and count update on the edge.
// Backpressure: a lock on an already-busy register is refused via lock_ok_w_o; decode must retry.
//
// Ports: clk_w_i/res_w_i_h clock and async active-high reset; rd_reg_x_w_i read indices with
// raw busy flags rd_busy_x_w_o; lock_reg_w_i/lock_flag_w_i lock request, lock_ok_w_o accept;
// ld_reg_w_i/ld_wr_flag_w_i load writeback clearing busy; busy_cnt_w_o number of busy registers.
module regfile_scoreboard
    import cpe_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_h,
    input  logic [ADDR_W-1:0] rd_reg_1_w_i,
    input  logic [ADDR_W-1:0] rd_reg_2_w_i,
    output logic              rd_busy_1_w_o,
    output logic              rd_busy_2_w_o,
    input  logic [ADDR_W-1:0] lock_reg_w_i,
    input  logic              lock_flag_w_i,
    output logic              lock_ok_w_o,
    input  logic [ADDR_W-1:0] ld_reg_w_i,
    input  logic              ld_wr_flag_w_i,
    output logic [ADDR_W:0]   busy_cnt_w_o
);

    localparam int              DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return {1'b0, idx} < NUM_REGS_L;
    endfunction

    // Register that may hold state: in range and not the hardwired zero register.
    function automatic logic writable(input logic [ADDR_W-1:0] idx);
        return in_range(idx) && !((ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX)));
    endfunction

    // Sized to the full index space so any index selects safely; out-of-range bits stay 0.
    logic [DEPTH-1:0] busy_q;
    logic [ADDR_W:0]  cnt_q;
    logic             clr;
    logic             inc;
    logic             dec;

    assign lock_ok_w_o = lock_flag_w_i && writable(lock_reg_w_i) && !busy_q[lock_reg_w_i];
    assign clr         = ld_wr_flag_w_i && writable(ld_reg_w_i);

    // An accepted lock on the index being cleared this cycle nets to a cleared bit,
    // so it must not count; the count always tracks the bit vector exactly.
    assign inc = lock_ok_w_o && !(clr && (ld_reg_w_i == lock_reg_w_i));
    assign dec = clr && busy_q[ld_reg_w_i];

    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (lock_ok_w_o) begin
                busy_q[lock_reg_w_i] <= 1'b1;
            end
            if (clr) begin
                busy_q[ld_reg_w_i] <= 1'b0;
            end
            cnt_q <= cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    assign rd_busy_1_w_o = in_range(rd_reg_1_w_i) && busy_q[rd_reg_1_w_i];
    assign rd_busy_2_w_o = in_range(rd_reg_2_w_i) && busy_q[rd_reg_2_w_i];
    assign busy_cnt_w_o  = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with ALU (A) and load (B) write ports plus per-register load scoreboard.
// Latency: reads combinational from state (write visible next cycle; same cycle with REGFILE_BYPASS_EN).
// Backpressure: none on writes; locks refused (lock_ok_w_o=0) while the target is busy.
//
// Ports: clk_w_i/res_w_i_h clock and async active-high reset; rd_reg_x_w_i -> rd_data_x_w_o,
// rd_busy_x_w_o read ports; wr_reg/wr_data/reg_wr_flag port A; ld_reg/ld_data/ld_wr_flag port B
// (also clears busy); lock_reg/lock_flag -> lock_ok; busy_cnt_w_o busy register count.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writes/clears to the read ports.
module regfile_sb
    import cpe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 2**ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_h,
    input  logic [ADDR_W-1:0] rd_reg_1_w_i,
    input  logic [ADDR_W-1:0] rd_reg_2_w_i,
    output logic [DATA_W-1:0] rd_data_1_w_o,
    output logic [DATA_W-1:0] rd_data_2_w_o,
    output logic              rd_busy_1_w_o,
    output logic              rd_busy_2_w_o,
    input  logic [ADDR_W-1:0] wr_reg_w_i,
    input  logic [DATA_W-1:0] wr_data_w_i,
    input  logic              reg_wr_flag_w_i,
    input  logic [ADDR_W-1:0] ld_reg_w_i,
    input  logic [DATA_W-1:0] ld_data_w_i,
    input  logic              ld_wr_flag_w_i,
    input  logic [ADDR_W-1:0] lock_reg_w_i,
    input  logic              lock_flag_w_i,
    output logic              lock_ok_w_o,
    output logic [ADDR_W:0]   busy_cnt_w_o
);

    localparam int              DEPTH      = 2**ADDR_W;
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return {1'b0, idx} < NUM_REGS_L;
    endfunction

    function automatic logic writable(input logic [ADDR_W-1:0] idx);
        return in_range(idx) && !((ZERO_REG != 0) && (idx == ADDR_W'(ZERO_IDX)));
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_a_ok;
    logic              wr_b_ok;
    logic              busy_1_raw;
    logic              busy_2_raw;

    assign wr_a_ok = reg_wr_flag_w_i && writable(wr_reg_w_i);
    assign wr_b_ok = ld_wr_flag_w_i && writable(ld_reg_w_i);

    // Port B is applied last so it wins a same-index collision with port A.
    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_a_ok) begin
                mem_q[wr_reg_w_i] <= wr_data_w_i;
            end
            if (wr_b_ok) begin
                mem_q[ld_reg_w_i] <= ld_data_w_i;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_w_i        (clk_w_i),
        .res_w_i_h      (res_w_i_h),
        .rd_reg_1_w_i   (rd_reg_1_w_i),
        .rd_reg_2_w_i   (rd_reg_2_w_i),
        .rd_busy_1_w_o  (busy_1_raw),
        .rd_busy_2_w_o  (busy_2_raw),
        .lock_reg_w_i   (lock_reg_w_i),
        .lock_flag_w_i  (lock_flag_w_i),
        .lock_ok_w_o    (lock_ok_w_o),
        .ld_reg_w_i     (ld_reg_w_i),
        .ld_wr_flag_w_i (ld_wr_flag_w_i),
        .busy_cnt_w_o   (busy_cnt_w_o)
    );

    // Register 0 is never written when hardwired, so mem_q[0] already reads zero there.
    always_comb begin
        rd_data_1_w_o = in_range(rd_reg_1_w_i) ? mem_q[rd_reg_1_w_i] : '0;
        rd_data_2_w_o = in_range(rd_reg_2_w_i) ? mem_q[rd_reg_2_w_i] : '0;
        rd_busy_1_w_o = busy_1_raw;
        rd_busy_2_w_o = busy_2_raw;
`ifdef REGFILE_BYPASS_EN
        // wr_x_ok already excludes register 0 and invalid indices, so those never forward.
        if (wr_b_ok && (ld_reg_w_i == rd_reg_1_w_i)) begin
            rd_data_1_w_o = ld_data_w_i;
            rd_busy_1_w_o = 1'b0;
        end else if (wr_a_ok && (wr_reg_w_i == rd_reg_1_w_i)) begin
            rd_data_1_w_o = wr_data_w_i;
        end
        if (wr_b_ok && (ld_reg_w_i == rd_reg_2_w_i)) begin
            rd_data_2_w_o = ld_data_w_i;
            rd_busy_2_w_o = 1'b0;
        end else if (wr_a_ok && (wr_reg_w_i == rd_reg_2_w_i)) begin
            rd_data_2_w_o = wr_data_w_i;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic vs. a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_sb;

    localparam int NREGS = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_reg_1 = '0, rd_reg_2 = '0;
    logic [31:0] rd_data_1, rd_data_2;
    logic        rd_busy_1, rd_busy_2;
    logic [4:0]  wr_reg = '0;
    logic [31:0] wr_data = '0;
    logic        reg_wr_flag = 1'b0;
    logic [4:0]  ld_reg = '0;
    logic [31:0] ld_data = '0;
    logic        ld_wr_flag = 1'b0;
    logic [4:0]  lock_reg = '0;
    logic        lock_flag = 1'b0;
    logic        lock_ok;
    logic [5:0]  busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural register contents and busy set.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(NREGS), .ZERO_REG(1)) dut (
        .clk_w_i         (clk),
        .res_w_i_h       (rst),
        .rd_reg_1_w_i    (rd_reg_1),
        .rd_reg_2_w_i    (rd_reg_2),
        .rd_data_1_w_o   (rd_data_1),
        .rd_data_2_w_o   (rd_data_2),
        .rd_busy_1_w_o   (rd_busy_1),
        .rd_busy_2_w_o   (rd_busy_2),
        .wr_reg_w_i      (wr_reg),
        .wr_data_w_i     (wr_data),
        .reg_wr_flag_w_i (reg_wr_flag),
        .ld_reg_w_i      (ld_reg),
        .ld_data_w_i     (ld_data),
        .ld_wr_flag_w_i  (ld_wr_flag),
        .lock_reg_w_i    (lock_reg),
        .lock_flag_w_i   (lock_flag),
        .lock_ok_w_o     (lock_ok),
        .busy_cnt_w_o    (busy_cnt)
    );

    function automatic bit holds_state(input logic [4:0] idx);
        return (int'(idx) < NREGS) && (idx != 5'd0);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (int'(idx) >= NREGS) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (holds_state(idx) && ld_wr_flag && ld_reg == idx) return ld_data;
        if (holds_state(idx) && reg_wr_flag && wr_reg == idx) return wr_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (int'(idx) >= NREGS) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (ld_wr_flag && ld_reg == idx) return 1'b0;
`endif
        return m_busy[idx];
    endfunction

    function automatic logic exp_lock();
        return lock_flag && holds_state(lock_reg) && !m_busy[lock_reg];
    endfunction

    // One clock edge of architectural behaviour: lock, then writes, with port B / clear last.
    task automatic model_step();
        bit acc;
        acc = exp_lock();
        if (acc) m_busy[lock_reg] = 1'b1;
        if (reg_wr_flag && holds_state(wr_reg)) m_regs[wr_reg] = wr_data;
        if (ld_wr_flag && holds_state(ld_reg)) begin
            m_regs[ld_reg] = ld_data;
            m_busy[ld_reg] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        reg_wr_flag = 1'b0;
        ld_wr_flag  = 1'b0;
        lock_flag   = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        idle();
        rst = 1'b1;
        rd_reg_1 = 5'd5;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt); end
        n_tests++;
        if (rd_data_1 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rd_data_1); end
        rst = 1'b0;
        @(negedge clk);
        wr_reg = 5'd5; wr_data = 32'hDEADBEEF; reg_wr_flag = 1'b1;
        lock_reg = 5'd6; lock_flag = 1'b1;
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_data_1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_r5: got %h expected deadbeef", rd_data_1); end
        n_tests++;
        if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL pre_reset_cnt: got %0d expected 1", busy_cnt); end
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (rd_data_1 !== 32'h0) begin n_fail++; $display("FAIL async_reset_r5: got %h expected 0", rd_data_1); end
        n_tests++;
        if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL async_reset_cnt: got %0d expected 0", busy_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_collision();
        wr_reg = 5'd7; wr_data = 32'h11; reg_wr_flag = 1'b1;
        ld_reg = 5'd7; ld_data = 32'h22; ld_wr_flag = 1'b1;
        rd_reg_2 = 5'd7;
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_data_2 !== 32'h22) begin n_fail++; $display("FAIL collision_r7: got %h expected 22", rd_data_2); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [5:0] cnt0;
        cnt0 = busy_cnt;
        wr_reg = 5'd0; wr_data = 32'hFFFFFFFF; reg_wr_flag = 1'b1;
        ld_reg = 5'd0; ld_data = 32'hFFFFFFFF; ld_wr_flag = 1'b1;
        lock_reg = 5'd0; lock_flag = 1'b1;
        rd_reg_1 = 5'd0;
        #1;
        n_tests++;
        if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL zero_lock_ok: got %b expected 0", lock_ok); end
        n_tests++;
        if (rd_data_1 !== 32'h0) begin n_fail++; $display("FAIL zero_read_same: got %h expected 0", rd_data_1); end
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_data_1 !== 32'h0) begin n_fail++; $display("FAIL zero_read: got %h expected 0", rd_data_1); end
        n_tests++;
        if (busy_cnt !== cnt0) begin n_fail++; $display("FAIL zero_cnt: got %0d expected %0d", busy_cnt, cnt0); end
        n_tests++;
        if (rd_busy_1 !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", rd_busy_1); end
        @(negedge clk);
    endtask

    task automatic test_lifecycle();
        rd_reg_1 = 5'd3;
        lock_reg = 5'd3; lock_flag = 1'b1;
        #1;
        n_tests++;
        if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL life_lock1: got %b expected 1", lock_ok); end
        tick();
        #1;
        n_tests++;
        if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL life_cnt1: got %0d expected 1", busy_cnt); end
        n_tests++;
        if (rd_busy_1 !== 1'b1) begin n_fail++; $display("FAIL life_busy1: got %b expected 1", rd_busy_1); end
        n_tests++;
        if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL life_lock2: got %b expected 0", lock_ok); end
        tick();
        lock_flag = 1'b0;
        #1;
        n_tests++;
        if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL life_cnt2: got %0d expected 1", busy_cnt); end
        ld_reg = 5'd3; ld_data = 32'h55; ld_wr_flag = 1'b1;
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL life_cnt3: got %0d expected 0", busy_cnt); end
        n_tests++;
        if (rd_busy_1 !== 1'b0) begin n_fail++; $display("FAIL life_busy3: got %b expected 0", rd_busy_1); end
        n_tests++;
        if (rd_data_1 !== 32'h55) begin n_fail++; $display("FAIL life_data: got %h expected 55", rd_data_1); end
        @(negedge clk);
    endtask

    task automatic test_lock_clear();
        lock_reg = 5'd3; lock_flag = 1'b1;
        tick();
        lock_reg = 5'd4;
        ld_reg = 5'd3; ld_data = 32'h77; ld_wr_flag = 1'b1;
        rd_reg_1 = 5'd4; rd_reg_2 = 5'd3;
        #1;
        n_tests++;
        if (lock_ok !== 1'b1) begin n_fail++; $display("FAIL lc_lock_ok: got %b expected 1", lock_ok); end
        tick();
        idle();
        #1;
        n_tests++;
        if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL lc_cnt: got %0d expected 1", busy_cnt); end
        n_tests++;
        if (rd_busy_1 !== 1'b1) begin n_fail++; $display("FAIL lc_busy_r4: got %b expected 1", rd_busy_1); end
        n_tests++;
        if (rd_busy_2 !== 1'b0) begin n_fail++; $display("FAIL lc_busy_r3: got %b expected 0", rd_busy_2); end
        ld_reg = 5'd4; ld_data = 32'h0; ld_wr_flag = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        old = m_regs[9];
        rd_reg_1 = 5'd9;
        wr_reg = 5'd9; wr_data = 32'hA5; reg_wr_flag = 1'b1;
        #1;
        n_tests++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data_1 !== 32'hA5) begin n_fail++; $display("FAIL bypass_same: got %h expected a5", rd_data_1); end
`else
        if (rd_data_1 !== old) begin n_fail++; $display("FAIL bypass_same: got %h expected %h", rd_data_1, old); end
`endif
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_data_1 !== 32'hA5) begin n_fail++; $display("FAIL bypass_next: got %h expected a5", rd_data_1); end
        @(negedge clk);
    endtask

    task automatic test_invalid();
        wr_reg = 5'd29; wr_data = 32'h1234; reg_wr_flag = 1'b1;
        lock_reg = 5'd30; lock_flag = 1'b1;
        rd_reg_1 = 5'd29; rd_reg_2 = 5'd30;
        #1;
        n_tests++;
        if (lock_ok !== 1'b0) begin n_fail++; $display("FAIL inv_lock_ok: got %b expected 0", lock_ok); end
        tick();
        idle();
        #1;
        n_tests++;
        if (rd_data_1 !== 32'h0) begin n_fail++; $display("FAIL inv_read: got %h expected 0", rd_data_1); end
        n_tests++;
        if (rd_busy_2 !== 1'b0) begin n_fail++; $display("FAIL inv_busy: got %b expected 0", rd_busy_2); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            lock_reg    = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(9));
            ld_reg      = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(9));
            wr_reg      = 5'($urandom_range(31));
            lock_flag   = ($urandom_range(9) < 6);
            ld_wr_flag  = ($urandom_range(9) < 4);
            reg_wr_flag = ($urandom_range(1) == 1);
            wr_data     = $urandom;
            ld_data     = $urandom;
            rd_reg_1    = ($urandom_range(1) == 1) ? ld_reg : 5'($urandom_range(31));
            rd_reg_2    = ($urandom_range(1) == 1) ? wr_reg : 5'($urandom_range(31));
            #1;
            n_tests++;
            if (lock_ok !== exp_lock()) begin n_fail++; $display("FAIL rnd_lock_ok[%0d]: got %b expected %b", n, lock_ok, exp_lock()); end
            n_tests++;
            if (rd_data_1 !== exp_rd(rd_reg_1)) begin n_fail++; $display("FAIL rnd_rd1[%0d]: got %h expected %h", n, rd_data_1, exp_rd(rd_reg_1)); end
            n_tests++;
            if (rd_data_2 !== exp_rd(rd_reg_2)) begin n_fail++; $display("FAIL rnd_rd2[%0d]: got %h expected %h", n, rd_data_2, exp_rd(rd_reg_2)); end
            n_tests++;
            if (rd_busy_1 !== exp_busy(rd_reg_1)) begin n_fail++; $display("FAIL rnd_busy1[%0d]: got %b expected %b", n, rd_busy_1, exp_busy(rd_reg_1)); end
            n_tests++;
            if (rd_busy_2 !== exp_busy(rd_reg_2)) begin n_fail++; $display("FAIL rnd_busy2[%0d]: got %b expected %b", n, rd_busy_2, exp_busy(rd_reg_2)); end
            n_tests++;
            if (int'(busy_cnt) !== m_count()) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, busy_cnt, m_count()); end
            tick();
        end
        idle();
        #1;
        n_tests++;
        if (int'(busy_cnt) !== m_count()) begin n_fail++; $display("FAIL rnd_cnt_end: got %0d expected %0d", busy_cnt, m_count()); end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_zero();
        test_lifecycle();
        test_lock_clear();
        test_bypass();
        test_invalid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
